// File: rtl/wbs_mem_bridge.sv
// Wishbone slave bridging the management bus to NUM_CH SRAM channels plus mode/debug/status
// registers, with 32-bit beat staging for writes and a one-word read cache.
module wbs_mem_bridge #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned WORD_W = 64,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                     wb_clk_i,
  input  logic                     rst_n,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_dat_i,
  input  logic [31:0]              wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic                     wbs_mode,
  output logic                     wbs_debug,
  output logic [NUM_CH-1:0]        mem_csb_o,
  output logic [NUM_CH-1:0]        mem_web_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [WORD_W-1:0]        mem_wdata_o,
  input  logic [NUM_CH*WORD_W-1:0] mem_rdata_i
);

  localparam int unsigned BEATS = (WORD_W + 31) / 32;
  localparam int unsigned BB    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SW    = BEATS * 32;
  localparam logic [2:0]  LAT_LAST = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACK, RD_ISSUE, RD_WAIT} state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d, debug_q, debug_d, err_q, err_d;
  logic                commit_q, commit_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [BB-1:0]       beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         dat_q, dat_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic                cache_valid_q, cache_valid_d;
  logic [CW-1:0]       cache_ch_q, cache_ch_d;
  logic [ADDR_W-1:0]   cache_addr_q, cache_addr_d;
  logic [WORD_W-1:0]   cache_word_q, cache_word_d;

  logic [31:0]         region32;
  logic [BB-1:0]       beat;
  logic [ADDR_W-1:0]   waddr;
  logic [CW-1:0]       ch_idx;
  logic                req, is_reg, ch_legal, hit, last_beat;
  logic [31:0]         reg_rdata;
  logic [WORD_W-1:0]   rd_word;
  logic                unused_adr;

  function automatic logic [31:0] beat_of(input logic [WORD_W-1:0] w, input logic [BB-1:0] b);
    logic [SW-1:0] p;
    p = SW'(w);
    return p[32*b +: 32];
  endfunction

  assign region32   = {24'd0, wbs_adr_i[31:24]};
  assign beat       = wbs_adr_i[BB-1:0];
  assign waddr      = wbs_adr_i[BB+ADDR_W-1:BB];
  assign ch_idx     = CW'(region32 - 32'h31);
  assign unused_adr = ^wbs_adr_i[23:BB+ADDR_W];
  assign req        = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign is_reg     = (region32 == 32'h30);
  assign ch_legal   = (region32 >= 32'h31) && (region32 < 32'h31 + NUM_CH)
                      && (32'(beat) < BEATS) && debug_q;
  assign hit        = cache_valid_q && (cache_ch_q == ch_idx) && (cache_addr_q == waddr);
  assign last_beat  = (32'(beat) == BEATS - 1);
  assign rd_word    = mem_rdata_i[ch_q*WORD_W +: WORD_W];

  always_comb begin
    unique case (wbs_adr_i[1:0])
      2'd0:    reg_rdata = {31'd0, mode_q};
      2'd1:    reg_rdata = {31'd0, debug_q};
      2'd2:    reg_rdata = {31'd0, err_q};
      default: reg_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (req) state_d = (ch_legal && !wbs_we_i && !hit) ? RD_ISSUE : ACK;
      ACK:      state_d = IDLE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  if (cnt_q == LAT_LAST) state_d = ACK;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    mode_d        = mode_q;
    debug_d       = debug_q;
    err_d         = err_q;
    commit_d      = 1'b0;
    cnt_d         = cnt_q;
    ch_d          = ch_q;
    beat_d        = beat_q;
    addr_d        = addr_q;
    dat_d         = dat_q;
    stage_d       = stage_q;
    cache_valid_d = cache_valid_q;
    cache_ch_d    = cache_ch_q;
    cache_addr_d  = cache_addr_q;
    cache_word_d  = cache_word_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          ch_d   = ch_idx;
          beat_d = beat;
          dat_d  = '0;
          if (is_reg) begin
            if (wbs_we_i) begin
              unique case (wbs_adr_i[1:0])
                2'd0:    if (wbs_sel_i[0]) mode_d = wbs_dat_i[0];
                2'd1:    if (wbs_sel_i[0]) debug_d = wbs_dat_i[0];
                2'd2:    if (wbs_sel_i[0] && wbs_dat_i[0]) err_d = 1'b0;
                default: ;
              endcase
            end else begin
              dat_d = reg_rdata;
            end
          end else if (ch_legal) begin
            addr_d = waddr;
            if (wbs_we_i) begin
              for (int unsigned i = 0; i < 4; i++) begin
                if (wbs_sel_i[i]) stage_d[32*beat + 8*i +: 8] = wbs_dat_i[8*i +: 8];
              end
              commit_d = last_beat;
              // Cache is patched at sample time; the SRAM commit follows one cycle later.
              if (cache_valid_q && cache_ch_q == ch_idx) begin
                if (last_beat && cache_addr_q == waddr) cache_word_d = stage_d[WORD_W-1:0];
                else                                    cache_valid_d = 1'b0;
              end
            end else if (hit) begin
              dat_d = beat_of(cache_word_q, beat);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RD_ISSUE: cnt_d = '0;
      RD_WAIT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAT_LAST) begin
          cache_valid_d = 1'b1;
          cache_ch_d    = ch_q;
          cache_addr_d  = addr_q;
          cache_word_d  = rd_word;
          dat_d         = beat_of(rd_word, beat_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      mode_q        <= 1'b0;
      debug_q       <= 1'b0;
      err_q         <= 1'b0;
      commit_q      <= 1'b0;
      cnt_q         <= '0;
      ch_q          <= '0;
      beat_q        <= '0;
      addr_q        <= '0;
      dat_q         <= '0;
      stage_q       <= '0;
      cache_valid_q <= 1'b0;
      cache_ch_q    <= '0;
      cache_addr_q  <= '0;
      cache_word_q  <= '0;
    end else begin
      mode_q        <= mode_d;
      debug_q       <= debug_d;
      err_q         <= err_d;
      commit_q      <= commit_d;
      cnt_q         <= cnt_d;
      ch_q          <= ch_d;
      beat_q        <= beat_d;
      addr_q        <= addr_d;
      dat_q         <= dat_d;
      stage_q       <= stage_d;
      cache_valid_q <= cache_valid_d;
      cache_ch_q    <= cache_ch_d;
      cache_addr_q  <= cache_addr_d;
      cache_word_q  <= cache_word_d;
    end
  end

  always_comb begin
    wbs_ack_o   = (state_q == ACK);
    wbs_dat_o   = dat_q;
    wbs_mode    = mode_q;
    wbs_debug   = debug_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = stage_q[WORD_W-1:0];
    mem_csb_o   = '1;
    mem_web_o   = '1;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (CW'(c) == ch_q) begin
        if (state_q == RD_ISSUE) mem_csb_o[c] = 1'b0;
        if (state_q == ACK && commit_q) begin
          mem_csb_o[c] = 1'b0;
          mem_web_o[c] = 1'b0;
        end
      end
    end
  end

endmodule
